// File: rtl/mdu_pkg.sv
// Shared types and defaults for the E-stage multiply/divide sequencer.
// Op encodings, FSM states and default latency constants.
package mdu_pkg;

  typedef enum logic [2:0] {
    MDU_NONE  = 3'd0,
    MDU_MULT  = 3'd1,
    MDU_MULTU = 3'd2,
    MDU_DIV   = 3'd3,
    MDU_DIVU  = 3'd4,
    MDU_MTHI  = 3'd5,
    MDU_MTLO  = 3'd6
  } mdu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2
  } mdu_state_e;

  localparam int MDU_WIDTH    = 32;
  localparam int MDU_MULT_CYC = 5;
  localparam int MDU_DIV_CYC  = 10;

endpackage

// File: rtl/mdu_seq_if.sv
// Issue/result bundle between the E stage and the MDU sequencer.
// master issues ops, slave (the sequencer) returns status and HI/LO.
interface mdu_seq_if
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] rs;
  logic [WIDTH-1:0] rt;
  logic             req;
  logic             busy;
  logic             stall_req;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, rs, rt, req,
    input  busy, stall_req, done, hi, lo
  );

  modport slave (
    input  start, op, rs, rt, req,
    output busy, stall_req, done, hi, lo
  );
endinterface

// File: rtl/mdu_arith.sv
// Combinational HI/LO result generator for MULT/MULTU/DIV/DIVU.
// Division works on magnitudes, then restores signs.
module mdu_arith
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input  mdu_op_e          op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi_n,
  output logic [WIDTH-1:0] lo_n,
  output logic             dz
);

  logic [2*WIDTH-1:0] prod_s;
  logic [2*WIDTH-1:0] prod_u;
  logic               sgn;
  logic               na;
  logic               nb;
  logic [WIDTH-1:0]   ma;
  logic [WIDTH-1:0]   mb;
  logic [WIDTH-1:0]   dv;
  logic [WIDTH-1:0]   qu;
  logic [WIDTH-1:0]   ru;
  logic [WIDTH-1:0]   q;
  logic [WIDTH-1:0]   r;

  assign prod_s = {{WIDTH{a[WIDTH-1]}}, a}
                * {{WIDTH{b[WIDTH-1]}}, b};
  assign prod_u = {{WIDTH{1'b0}}, a}
                * {{WIDTH{1'b0}}, b};

  // MIN/-1 falls out naturally: |MIN| negates back to MIN, rem 0
  assign sgn = (op == MDU_DIV);
  assign na  = sgn & a[WIDTH-1];
  assign nb  = sgn & b[WIDTH-1];
  assign ma  = na ? -a : a;
  assign mb  = nb ? -b : b;
  assign dv  = (b == '0) ? WIDTH'(1) : mb;
  assign qu  = ma / dv;
  assign ru  = ma % dv;
  assign q   = (na ^ nb) ? -qu : qu;
  assign r   = na ? -ru : ru;

  always_comb begin
    hi_n = '0;
    lo_n = '0;
    dz   = 1'b0;
    unique case (op)
      MDU_MULT: begin
        hi_n = prod_s[2*WIDTH-1:WIDTH];
        lo_n = prod_s[WIDTH-1:0];
      end
      MDU_MULTU: begin
        hi_n = prod_u[2*WIDTH-1:WIDTH];
        lo_n = prod_u[WIDTH-1:0];
      end
      MDU_DIV, MDU_DIVU: begin
        hi_n = r;
        lo_n = q;
        dz   = (b == '0);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mdu_seq.sv
// E-stage multiply/divide sequencer: latches operands, times latency,
// commits HI/LO, and raises busy/stall_req to the hazard unit.
module mdu_seq
  import mdu_pkg::*;
#(
  parameter int WIDTH    = MDU_WIDTH,
  parameter int MULT_CYC = MDU_MULT_CYC,
  parameter int DIV_CYC  = MDU_DIV_CYC
) (
  input logic       clk,
  input logic       reset,
  mdu_seq_if.slave  bus
);

  localparam int MAXC = (MULT_CYC > DIV_CYC)
                      ? MULT_CYC : DIV_CYC;
  localparam int CW   = $clog2(MAXC + 1);

  mdu_state_e       state_q;
  logic [CW-1:0]    cnt_q;
  mdu_op_e          op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic             busy_q;
  logic             done_q;

  logic [WIDTH-1:0] hi_n;
  logic [WIDTH-1:0] lo_n;
  logic             dz;
  mdu_op_e          op_in;
  logic             go;
  logic             is_mul;
  logic             is_div;
  logic             is_mthi;
  logic             is_mtlo;

  mdu_arith #(
    .WIDTH (WIDTH)
  ) u_arith (
    .op   (op_q),
    .a    (a_q),
    .b    (b_q),
    .hi_n (hi_n),
    .lo_n (lo_n),
    .dz   (dz)
  );

  assign op_in   = mdu_op_e'(bus.op);
  assign go      = bus.start & ~bus.req;
  assign is_mul  = go & (op_in == MDU_MULT
                      || op_in == MDU_MULTU);
  assign is_div  = go & (op_in == MDU_DIV
                      || op_in == MDU_DIVU);
  assign is_mthi = go & (op_in == MDU_MTHI);
  assign is_mtlo = go & (op_in == MDU_MTLO);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= MDU_NONE;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          unique case (1'b1)
            is_mul: begin
              state_q <= MUL;
              cnt_q   <= CW'(MULT_CYC - 1);
              busy_q  <= 1'b1;
              done_q  <= (MULT_CYC == 1);
              op_q    <= op_in;
              a_q     <= bus.rs;
              b_q     <= bus.rt;
            end
            is_div: begin
              state_q <= DIV;
              cnt_q   <= CW'(DIV_CYC - 1);
              busy_q  <= 1'b1;
              done_q  <= (DIV_CYC == 1);
              op_q    <= op_in;
              a_q     <= bus.rs;
              b_q     <= bus.rt;
            end
            is_mthi: hi_q <= bus.rs;
            is_mtlo: lo_q <= bus.rs;
            default: ;
          endcase
        end
        MUL, DIV: begin
          if (cnt_q != '0) begin
            cnt_q  <= cnt_q - 1'b1;
            done_q <= (cnt_q == CW'(1));
          end else begin
            if (!dz) begin
              hi_q <= hi_n;
              lo_q <= lo_n;
            end
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.hi        = hi_q;
  assign bus.lo        = lo_q;
  assign bus.stall_req = busy_q | is_mul | is_div;

  // the hazard unit must hold new MDU ops while one is in flight
  a_no_start_busy: assert property (
    @(posedge clk) disable iff (!reset)
    !(go && busy_q)
  );

endmodule

// File: tb/tb_mdu_seq.sv
// Directed bench for mdu_seq: latency, arithmetic, req, reset.
// Expected values are hand-computed per vector.
module tb_mdu_seq;
  import mdu_pkg::*;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  mdu_seq_if #(.WIDTH(32)) bus ();

  mdu_seq dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input string tag,
                        input logic [2:0] op,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        input int n,
                        input int req_at,
                        input logic [31:0] ehi,
                        input logic [31:0] elo);
    bus.start = 1'b1;
    bus.op    = op;
    bus.rs    = a;
    bus.rt    = b;
    #1;
    chk({tag, ".stall_T"}, 64'(bus.stall_req), 64'd1);
    tick();
    bus.start = 1'b0;
    bus.op    = 3'd0;
    for (int i = 1; i <= n; i++) begin
      bus.req = (i == req_at);
      #1;
      chk({tag, ".busy"}, 64'(bus.busy), 64'd1);
      chk({tag, ".stall"}, 64'(bus.stall_req), 64'd1);
      chk({tag, ".done"}, 64'(bus.done),
          64'(i == n));
      tick();
    end
    bus.req = 1'b0;
    #1;
    chk({tag, ".busy_end"}, 64'(bus.busy), 64'd0);
    chk({tag, ".done_end"}, 64'(bus.done), 64'd0);
    chk({tag, ".hi"}, 64'(bus.hi), 64'(ehi));
    chk({tag, ".lo"}, 64'(bus.lo), 64'(elo));
  endtask

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.op    = 3'd0;
    bus.rs    = '0;
    bus.rt    = '0;
    bus.req   = 1'b0;
    tick();
    tick();
    chk("rst.busy", 64'(bus.busy), 64'd0);
    chk("rst.done", 64'(bus.done), 64'd0);
    chk("rst.hi", 64'(bus.hi), 64'd0);
    chk("rst.lo", 64'(bus.lo), 64'd0);
    chk("rst.stall", 64'(bus.stall_req), 64'd0);
    rst_n = 1'b1;
    tick();

    run_op("mult", 3'd1, 32'hFFFFFFFE, 32'd3, 5, 0,
           32'hFFFFFFFF, 32'hFFFFFFFA);
    run_op("multu", 3'd2, 32'hFFFFFFFE, 32'd3, 5, 0,
           32'h00000002, 32'hFFFFFFFA);
    run_op("div", 3'd3, 32'hFFFFFFF9, 32'd2, 10, 0,
           32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("divmin", 3'd3, 32'h80000000,
           32'hFFFFFFFF, 10, 0,
           32'h00000000, 32'h80000000);
    run_op("divu", 3'd4, 32'd7, 32'd2, 10, 0,
           32'd1, 32'd3);
    run_op("div0", 3'd3, 32'd5, 32'd0, 10, 0,
           32'd1, 32'd3);

    // MULT issued under a flush must not start
    bus.start = 1'b1;
    bus.op    = 3'd1;
    bus.rs    = 32'd9;
    bus.rt    = 32'd9;
    bus.req   = 1'b1;
    #1;
    chk("mreq.stall", 64'(bus.stall_req), 64'd0);
    tick();
    bus.start = 1'b0;
    bus.req   = 1'b0;
    chk("mreq.busy", 64'(bus.busy), 64'd0);
    tick();
    tick();
    chk("mreq.busy2", 64'(bus.busy), 64'd0);
    chk("mreq.hi", 64'(bus.hi), 64'd1);
    chk("mreq.lo", 64'(bus.lo), 64'd3);

    run_op("reqbusy", 3'd1, 32'h10, 32'h20, 5, 2,
           32'd0, 32'h200);

    bus.start = 1'b1;
    bus.op    = 3'd5;
    bus.rs    = 32'h1234;
    #1;
    chk("mthi.stall", 64'(bus.stall_req), 64'd0);
    tick();
    bus.start = 1'b0;
    chk("mthi.hi", 64'(bus.hi), 64'h1234);
    chk("mthi.lo", 64'(bus.lo), 64'h200);
    chk("mthi.busy", 64'(bus.busy), 64'd0);

    bus.start = 1'b1;
    bus.op    = 3'd6;
    bus.rs    = 32'hABCD;
    bus.req   = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.req   = 1'b0;
    chk("mtloreq.lo", 64'(bus.lo), 64'h200);

    bus.start = 1'b1;
    bus.op    = 3'd6;
    bus.rs    = 32'h55;
    tick();
    bus.start = 1'b0;
    chk("mtlo.lo", 64'(bus.lo), 64'h55);
    chk("mtlo.hi", 64'(bus.hi), 64'h1234);

    bus.start = 1'b1;
    bus.op    = 3'd0;
    bus.rs    = 32'h77;
    tick();
    bus.op    = 3'd7;
    tick();
    bus.start = 1'b0;
    chk("nop.busy", 64'(bus.busy), 64'd0);
    chk("nop.hi", 64'(bus.hi), 64'h1234);
    chk("nop.lo", 64'(bus.lo), 64'h55);

    // reset lands in the third busy cycle of a DIV
    bus.start = 1'b1;
    bus.op    = 3'd3;
    bus.rs    = 32'd100;
    bus.rt    = 32'd7;
    tick();
    bus.start = 1'b0;
    bus.op    = 3'd0;
    tick();
    tick();
    chk("rmid.busy_pre", 64'(bus.busy), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("rmid.busy", 64'(bus.busy), 64'd0);
    chk("rmid.hi", 64'(bus.hi), 64'd0);
    chk("rmid.lo", 64'(bus.lo), 64'd0);
    chk("rmid.done", 64'(bus.done), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();

    run_op("post", 3'd1, 32'd6, 32'd7, 5, 0,
           32'd0, 32'd42);
    run_op("b2b_mul", 3'd1, 32'hFFFFFFFF,
           32'hFFFFFFFF, 5, 0, 32'd0, 32'd1);
    run_op("b2b_div", 3'd3, 32'd100, 32'hFFFFFFF9,
           10, 0, 32'd2, 32'hFFFFFFF2);

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
